// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C receive path: FSM states, default address, byte size.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_DATA,
        ST_ACK_DATA,
        ST_IGNORE
    } i2c_state_t;

    localparam logic [6:0]  I2C_DEFAULT_ADDR  = 7'h50;
    localparam int unsigned I2C_BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one I2C pin plus previous-sample register for edge detection.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Reset to 1 so an idle (pulled-up) bus produces no spurious edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/i2c_slave_rx.sv
// Receive-only I2C target: START/STOP detection, 7-bit address match, ACK and byte hand-off.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    input  logic       i2c_sda,
    output logic       sda_pull,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       addr_hit,
    output logic       bus_busy
);

    localparam int unsigned CNT_W   = $clog2(I2C_BITS_PER_BYTE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(I2C_BITS_PER_BYTE - 1);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;
    logic w_start, w_stop, w_last;
    logic [7:0] w_byte;

    i2c_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_shift;
    logic             r_ack_phase;
    logic             r_nack;
    logic             r_sda_pull;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_addr_hit;
    logic             r_bus_busy;

    i2c_line_sync u_scl_sync (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (i2c_scl),
        .o_level (w_scl_lvl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (i2c_sda),
        .o_level (w_sda_lvl),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl_lvl;
    assign w_stop  = w_sda_rise & w_scl_lvl;
    assign w_byte  = {r_shift[6:0], w_sda_lvl};
    assign w_last  = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_MAX;
            r_shift     <= '0;
            r_ack_phase <= 1'b0;
            r_nack      <= 1'b0;
            r_sda_pull  <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_addr_hit  <= 1'b0;
            r_bus_busy  <= 1'b0;
        end else begin
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            // Bus conditions override bit handling; a partial byte is simply abandoned.
            if (w_stop) begin
                r_state     <= ST_IDLE;
                r_sda_pull  <= 1'b0;
                r_addr_hit  <= 1'b0;
                r_bus_busy  <= 1'b0;
                r_ack_phase <= 1'b0;
            end else if (w_start) begin
                r_state     <= ST_ADDR;
                r_cnt       <= CNT_MAX;
                r_shift     <= '0;
                r_sda_pull  <= 1'b0;
                r_addr_hit  <= 1'b0;
                r_bus_busy  <= 1'b1;
                r_ack_phase <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt - CNT_W'(1);
                            if (w_last) begin
                                if (w_byte[7:1] == SLAVE_ADDR && !w_byte[0]) begin
                                    r_state <= ST_ACK_ADDR;
                                    r_nack  <= 1'b0;
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt - CNT_W'(1);
                            if (w_last) begin
                                r_state <= ST_ACK_DATA;
                                // An unconsumed byte means overrun: drop the new one and NACK.
                                if (!r_rx_valid) begin
                                    r_rx_data  <= w_byte;
                                    r_rx_valid <= 1'b1;
                                    r_nack     <= 1'b0;
                                end else begin
                                    r_nack <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_ACK_ADDR, ST_ACK_DATA: begin
                        // First SCL fall opens the ACK slot, the second closes it.
                        if (w_scl_fall) begin
                            if (!r_ack_phase) begin
                                r_ack_phase <= 1'b1;
                                r_sda_pull  <= ~r_nack;
                                if (r_state == ST_ACK_ADDR) begin
                                    r_addr_hit <= 1'b1;
                                end
                            end else begin
                                r_ack_phase <= 1'b0;
                                r_sda_pull  <= 1'b0;
                                r_state     <= ST_DATA;
                                r_cnt       <= CNT_MAX;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_pull = r_sda_pull;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign addr_hit = r_addr_hit;
    assign bus_busy = r_bus_busy;

endmodule

// File: doc/i2c_slave_rx.md
# i2c_slave_rx

- Receive-only I2C target (slave) that sits directly downstream of the team's I2C master write sequencer on the same SCL/SDA pair.
- Oversamples both lines on the system clock, detects START/STOP, and matches the 7-bit address.
- ACKs an accepted write, shifts in each data byte, and presents it on a valid/ready byte interface.
- It is the bench partner for the master and the receive front-end for later register-file blocks.

## Interface
- SLAVE_ADDR, 7'h50: 7-bit address this target responds to.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- i2c_scl  in  1  SCL pin level, asynchronous to clk.
- i2c_sda  in  1  SDA pin level, asynchronous to clk.
- sda_pull  out  1  1 = drive SDA low (open-drain ACK); 0 = release.
- rx_data  out  8  last accepted data byte; stable while rx_valid = 1.
- rx_valid  out  1  byte available; held until consumed.
- rx_ready  in  1  consumer accepts the byte when rx_valid & rx_ready.
- addr_hit  out  1  level; high from address ACK until STOP or repeated START.
- bus_busy  out  1  level; high from any START until STOP.

## Operation
- Both pins pass through 2-flop synchronizers. Edge detection compares the synced value with its previous sample.
- START: synced SDA falls while synced SCL = 1. STOP: synced SDA rises while synced SCL = 1.
- START and STOP are recognised in every state and take priority over bit handling in the same cycle.
- FSM states: IDLE, ADDR, ACK_ADDR, DATA, ACK_DATA, IGNORE.
- IDLE -> ADDR on START. Bit counter = 7; shift register is cleared.
- ADDR: on each SCL rise, shift in SDA MSB-first; 8 bits total (7 address bits + R/W).
  - After the 8th bit: if address = SLAVE_ADDR and R/W = 0, go to ACK_ADDR.
  - Otherwise (mismatch or read request), go to IGNORE with no ACK.
- ACK_ADDR: set sda_pull on the next SCL fall and set addr_hit. Release sda_pull on the following SCL fall, then go to DATA with counter = 7.
- DATA: shift 8 bits on SCL rises. The ACK decision is made in the cycle the 8th bit is sampled.
  - If rx_valid = 0: load rx_data, set rx_valid, go to ACK_DATA (ACK).
  - If rx_valid = 1 (overrun): drop the byte, keep rx_data unchanged, go to ACK_DATA with NACK. sda_pull stays 0 for that slot.
- ACK_DATA: same pull/release timing as ACK_ADDR, then return to DATA. Consecutive bytes continue until STOP.
- IGNORE: sda_pull = 0. Leave only on STOP (-> IDLE) or START (-> ADDR).
- STOP in any state: go to IDLE, release sda_pull in the same cycle, clear addr_hit and bus_busy. rx_valid and rx_data are retained.
- Repeated START in any state: go to ADDR, release sda_pull, clear addr_hit. bus_busy stays 1.
- Incomplete byte at STOP/START: discard it; rx_valid does not assert.
- rx_valid clears on the cycle after rx_valid & rx_ready.
  - If clear and load coincide, the load wins and rx_valid stays 1.
  - This case only arises when rx_valid was 0 at the decision point, so it does not happen in legal use.

## Timing
- Reset values: sda_pull = 0, rx_data = 8'h00, rx_valid = 0, addr_hit = 0, bus_busy = 0, state = IDLE, synchronizers = 1 (idle bus).
- Reset mid-transfer: all of the above take effect at the first clk edge with rst = 0. SDA is released within 1 cycle.
- Pin-to-detection latency: 3 clk (2 sync + 1 edge register).
- sda_pull changes 1 clk after the synced SCL fall is detected.
- rx_valid rises 1 clk after the synced SCL rise that samples the 8th data bit.
- Requirement on the bus: SCL high and low phases each ≥ 4 clk. Slower clk gives undefined behaviour.

## Structure
- Shared package i2c_pkg holds:
  - state enumeration localparams (IDLE..IGNORE);
  - I2C_DEFAULT_ADDR = 7'h50;
  - I2C_BITS_PER_BYTE = 8.
- One sub-module, i2c_line_sync: 2-flop synchronizer plus previous-sample register. Outputs are level, rise and fall. It is instantiated once for SCL and once for SDA.

## Test plan
- START, 0x50 + W (0xA0), 0xAA, STOP, with rx_ready = 1:
  - sda_pull high during both 9th-clock slots;
  - rx_data = 0xAA and rx_valid pulses;
  - addr_hit high until STOP.
- START, 0x51 + W, 0x55, STOP -> sda_pull never asserts; rx_valid stays 0; addr_hit = 0; bus_busy high until STOP.
- START, 0x50 + R (0xA1) -> NACK; FSM in IGNORE; no rx_valid.
- Write 0x11 then 0x22 with rx_ready = 0 -> first byte ACKed (rx_data = 0x11), second byte NACKed, rx_data still 0x11.
- STOP after 4 data bits -> IDLE, sda_pull = 0, rx_valid unchanged. A following START/0xA0/0x3C delivers rx_data = 0x3C.
- rst = 0 while sda_pull = 1 during the ACK slot -> sda_pull = 0 and all outputs at reset values one clk later.
